// File: rtl/fft_pkg.sv
// Shared constants and state type for the radix-2 SDF FFT stage sequencer.
package fft_pkg;
  localparam int FFT_N         = 512;
  localparam int LANES         = 16;
  localparam int FRAME_BEATS   = FFT_N / LANES;
  localparam int HALF_BEATS    = FRAME_BEATS / 2;
  localparam int BEAT_W        = $clog2(FRAME_BEATS);
  localparam int CNT_W         = $clog2(HALF_BEATS);
  localparam int DRAIN_TIMEOUT = 4;

  typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} seq_state_t;
endpackage

// File: rtl/fft_stage_seq_cnt.sv
// Wrapping up-counter with enable and synchronous clear; counts 0..MAX_VAL.
module fft_stage_seq_cnt #(
  parameter int WIDTH   = 5,
  parameter int MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == WIDTH'(MAX_VAL)) ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/fft_stage_seq.sv
// Sequencer for one radix-2 SDF FFT stage: steers delay line, butterfly and
// twiddle stage per accepted beat, with a self-timed drain of leftover diffs.
module fft_stage_seq
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             flush,
  output logic             shift_en,
  output logic             bfly_en,
  output logic             twd_valid,
  output logic             twd_half,
  output logic [CNT_W-1:0] twd_cnt,
  output logic             frame_done,
  output logic             busy
);
  localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(DRAIN_TIMEOUT);

  seq_state_t        state_q, state_d;
  logic              pending_q, pending_d;
  logic [TO_W-1:0]   timeout_q, timeout_d;
  logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [BEAT_W-1:0] beat_cnt;
  logic              beat;

  logic             din_ready_q, din_ready_d;
  logic             shift_en_q, shift_en_d;
  logic             bfly_en_q, bfly_en_d;
  logic             twd_valid_q, twd_valid_d;
  logic             twd_half_q, twd_half_d;
  logic [CNT_W-1:0] twd_cnt_q, twd_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  assign beat = din_valid & din_ready_q;

  fft_stage_seq_cnt #(.WIDTH(BEAT_W), .MAX_VAL(FRAME_BEATS - 1)) u_beat_cnt (
    .clk  (clk),
    .rstn (rstn),
    .en   (beat),
    .clr  (flush),
    .cnt  (beat_cnt)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d      = state_q;
    pending_d    = pending_q;
    timeout_d    = beat ? '0 : ((timeout_q == TO_MAX) ? timeout_q : timeout_q + TO_W'(1));
    drain_cnt_d  = '0;
    shift_en_d   = 1'b0;
    bfly_en_d    = 1'b0;
    twd_valid_d  = 1'b0;
    twd_half_d   = twd_half_q;
    twd_cnt_d    = twd_cnt_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE, FILL: begin
        if (beat) begin
          // New samples enter while the previous frame's diffs leave.
          state_d    = FILL;
          shift_en_d = 1'b1;
          twd_half_d = 1'b1;
          twd_cnt_d  = beat_cnt[CNT_W-1:0];
          if (pending_q) begin
            twd_valid_d = 1'b1;
            if (beat_cnt == BEAT_W'(HALF_BEATS - 1)) begin
              frame_done_d = 1'b1;
              pending_d    = 1'b0;
            end
          end
          if (beat_cnt == BEAT_W'(HALF_BEATS - 1)) state_d = BFLY;
        end else if (state_q == FILL && beat_cnt == '0) begin
          if (!pending_q)               state_d = IDLE;
          else if (timeout_d == TO_MAX) state_d = DRAIN;
        end
      end
      BFLY: begin
        if (beat) begin
          shift_en_d  = 1'b1;
          bfly_en_d   = 1'b1;
          twd_valid_d = 1'b1;
          twd_half_d  = 1'b0;
          twd_cnt_d   = beat_cnt[CNT_W-1:0];
          if (beat_cnt == BEAT_W'(FRAME_BEATS - 1)) begin
            state_d   = FILL;
            pending_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        shift_en_d  = 1'b1;
        twd_valid_d = 1'b1;
        twd_half_d  = 1'b1;
        twd_cnt_d   = drain_cnt_q;
        drain_cnt_d = drain_cnt_q + CNT_W'(1);
        if (drain_cnt_q == CNT_W'(HALF_BEATS - 1)) begin
          frame_done_d = 1'b1;
          pending_d    = 1'b0;
          drain_cnt_d  = '0;
          state_d      = IDLE;
        end
      end
    endcase

    if (flush) begin
      state_d      = IDLE;
      pending_d    = 1'b0;
      timeout_d    = '0;
      drain_cnt_d  = '0;
      shift_en_d   = 1'b0;
      bfly_en_d    = 1'b0;
      twd_valid_d  = 1'b0;
      twd_half_d   = 1'b0;
      twd_cnt_d    = '0;
      frame_done_d = 1'b0;
    end

    din_ready_d = (state_d != DRAIN);
    busy_d      = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      timeout_q    <= '0;
      drain_cnt_q  <= '0;
      din_ready_q  <= 1'b1;
      shift_en_q   <= 1'b0;
      bfly_en_q    <= 1'b0;
      twd_valid_q  <= 1'b0;
      twd_half_q   <= 1'b0;
      twd_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      timeout_q    <= timeout_d;
      drain_cnt_q  <= drain_cnt_d;
      din_ready_q  <= din_ready_d;
      shift_en_q   <= shift_en_d;
      bfly_en_q    <= bfly_en_d;
      twd_valid_q  <= twd_valid_d;
      twd_half_q   <= twd_half_d;
      twd_cnt_q    <= twd_cnt_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign din_ready  = din_ready_q;
  assign shift_en   = shift_en_q;
  assign bfly_en    = bfly_en_q;
  assign twd_valid  = twd_valid_q;
  assign twd_half   = twd_half_q;
  assign twd_cnt    = twd_cnt_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_fft_stage_seq.sv
// Scoreboard bench for fft_stage_seq: a frame-level reference model predicts
// per-cycle handshake/status and the stream of datapath control events.
module tb_fft_stage_seq;
  import fft_pkg::*;

  logic             clk = 1'b0;
  logic             rstn, din_valid, din_ready, flush;
  logic             shift_en, bfly_en, twd_valid, twd_half, frame_done, busy;
  logic [CNT_W-1:0] twd_cnt;

  fft_stage_seq dut (
    .clk        (clk),
    .rstn       (rstn),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .flush      (flush),
    .shift_en   (shift_en),
    .bfly_en    (bfly_en),
    .twd_valid  (twd_valid),
    .twd_half   (twd_half),
    .twd_cnt    (twd_cnt),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             shift, bfly, valid, half;
    logic [CNT_W-1:0] cnt;
    logic             fd;
  } evt_t;

  typedef struct packed {
    logic             active, ready, busy, zero, hold_ok;
    logic [CNT_W-1:0] hold_cnt;
  } cyc_t;

  evt_t evt_q[$];
  cyc_t cyc_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: frame position, owed diffs, idle run, drain progress.
  int   m_pos = 0, m_idle = 0, m_drain_left = 0;
  bit   m_owed = 0, m_in_frame = 0, m_ready = 1, m_busy = 0;
  bit   m_hold_ok = 0;
  int   m_hold_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit v, input bit f, input bit r);
    cyc_t c;
    evt_t e;
    c = '0;
    e = '0;
    if (!r || f) begin
      m_pos = 0; m_owed = 0; m_in_frame = 0; m_drain_left = 0; m_idle = 0;
      m_ready = 1; m_busy = 0; m_hold_ok = 1; m_hold_cnt = 0;
      c.zero = 1'b1;
    end else if (m_drain_left > 0) begin
      e.shift = 1'b1; e.valid = 1'b1; e.half = 1'b1;
      e.cnt   = CNT_W'(HALF_BEATS - m_drain_left);
      e.fd    = (m_drain_left == 1);
      m_drain_left--;
      if (m_drain_left == 0) begin
        m_owed = 0; m_in_frame = 0; m_ready = 1; m_busy = 0;
      end
    end else if (v) begin
      m_idle = 0; m_in_frame = 1; m_busy = 1;
      e.shift = 1'b1;
      if (m_pos < HALF_BEATS) begin
        e.valid = m_owed; e.half = 1'b1; e.cnt = CNT_W'(m_pos);
        e.fd = m_owed && (m_pos == HALF_BEATS - 1);
        if (e.fd) m_owed = 0;
      end else begin
        e.bfly = 1'b1; e.valid = 1'b1; e.half = 1'b0;
        e.cnt = CNT_W'(m_pos - HALF_BEATS);
      end
      m_pos++;
      if (m_pos == FRAME_BEATS) begin
        m_pos = 0; m_owed = 1;
      end
    end else begin
      if (m_idle < 1000) m_idle++;
      if (m_in_frame && m_pos == 0) begin
        if (!m_owed) begin
          m_in_frame = 0; m_busy = 0;
        end else if (m_idle >= DRAIN_TIMEOUT) begin
          m_drain_left = HALF_BEATS; m_ready = 0;
        end
      end
    end
    if (e.shift) begin
      c.active = 1'b1;
      evt_q.push_back(e);
      m_hold_ok = e.valid;
      m_hold_cnt = int'(e.cnt);
    end
    c.ready = m_ready; c.busy = m_busy; c.hold_ok = m_hold_ok;
    c.hold_cnt = CNT_W'(m_hold_cnt);
    cyc_q.push_back(c);
  endtask

  task automatic drive(input bit v, input bit f, input bit r);
    din_valid = v; flush = f; rstn = r;
    model_step(v, f, r);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs of the previous edge are compared at the falling edge.
  initial begin
    cyc_t c;
    evt_t e;
    logic act;
    forever begin
      @(negedge clk);
      if (cyc_q.size() != 0) begin
        c = cyc_q.pop_front();
        check("din_ready", 32'(din_ready), 32'(c.ready));
        check("busy", 32'(busy), 32'(c.busy));
        if (c.zero)
          check("reset_outputs",
                32'({shift_en, bfly_en, twd_valid, twd_half, twd_cnt, frame_done}), 32'd0);
        act = shift_en | bfly_en | twd_valid | frame_done;
        check("activity", 32'(act), 32'(c.active));
        if (act === 1'b1) begin
          if (evt_q.size() == 0) begin
            check("unexpected_event", 32'd1, 32'd0);
          end else begin
            e = evt_q.pop_front();
            check("shift_en", 32'(shift_en), 32'(e.shift));
            check("bfly_en", 32'(bfly_en), 32'(e.bfly));
            check("twd_valid", 32'(twd_valid), 32'(e.valid));
            check("frame_done", 32'(frame_done), 32'(e.fd));
            if (e.valid) begin
              check("twd_half", 32'(twd_half), 32'(e.half));
              check("twd_cnt", 32'(twd_cnt), 32'(e.cnt));
            end
          end
        end else if (c.hold_ok) begin
          check("twd_cnt_hold", 32'(twd_cnt), 32'(c.hold_cnt));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idle_burst;
    int r;
    bit v;
    din_valid = 1'b0; flush = 1'b0; rstn = 1'b0;
    repeat (2) drive(0, 0, 0);
    // Two back-to-back frames, then self-drain of frame 2 diffs.
    repeat (64) drive(1, 0, 1);
    repeat (25) drive(0, 0, 1);
    // One frame, drain, with valid held during drain.
    repeat (32) drive(1, 0, 1);
    repeat (4) drive(0, 0, 1);
    repeat (30) drive(1, 0, 1);
    repeat (25) drive(0, 0, 1);
    // Alternating gaps across two frames.
    for (int i = 0; i < 140; i++) drive(i % 2 == 0, 0, 1);
    repeat (25) drive(0, 0, 1);
    // Flush on beat 20 together with valid.
    repeat (19) drive(1, 0, 1);
    drive(1, 1, 1);
    repeat (40) drive(1, 0, 1);
    drive(0, 1, 1);
    // Reset in the middle of a drain.
    repeat (32) drive(1, 0, 1);
    repeat (9) drive(0, 0, 1);
    drive(0, 0, 0);
    repeat (5) drive(0, 0, 1);
    // Next frame resumes after exactly 3 idle cycles: no drain.
    repeat (32) drive(1, 0, 1);
    repeat (3) drive(0, 0, 1);
    repeat (32) drive(1, 0, 1);
    repeat (25) drive(0, 0, 1);
    // Randomized traffic with idle bursts, rare flush and reset.
    idle_burst = 0;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 199));
      if (idle_burst > 0) begin
        v = 1'b0;
        idle_burst--;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        if (r >= 190) idle_burst = int'($urandom_range(2, 8));
      end
      drive(v, r == 0, r != 1);
    end
    repeat (30) drive(0, 0, 1);
    repeat (2) @(negedge clk);
    check("events_drained", 32'(evt_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
